// File: rtl/retry_pkg.sv
// Shared types and helpers for the retry_budget_start slice.
package retry_pkg;

  typedef enum logic {
    FREE     = 1'b0,
    INFLIGHT = 1'b1
  } entry_state_e;

  typedef enum logic {
    IDLE    = 1'b0,
    PENDING = 1'b1
  } pending_state_e;

  // Bits needed for a per-entry counter that runs 0..max_retries.
  function automatic int retry_cnt_width(input int max_retries);
    return (max_retries < 1) ? 1 : $clog2(max_retries + 1);
  endfunction

endpackage

// File: rtl/retry_entry_table.sv
// Storage for in-flight items: payload, FREE/INFLIGHT state and a retry
// counter per ID. One write port (new item), one counter increment port
// (retry issued), two free ports (done and budget exhaustion) and
// combinational read ports for payload and retry count.
module retry_entry_table
  import retry_pkg::*;
#(
  parameter type         DataType = logic,
  parameter int unsigned ID_SIZE  = 4,
  parameter int unsigned CNT_W    = 2
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    wr_en,
  input  logic [ID_SIZE-1:0]      wr_id,
  input  DataType                 wr_data,
  input  logic                    inc_en,
  input  logic [ID_SIZE-1:0]      inc_id,
  input  logic                    free_a_en,
  input  logic [ID_SIZE-1:0]      free_a_id,
  input  logic                    free_b_en,
  input  logic [ID_SIZE-1:0]      free_b_id,
  input  logic [ID_SIZE-1:0]      rd_id,
  output DataType                 rd_data,
  input  logic [ID_SIZE-1:0]      cnt_id,
  output logic [CNT_W-1:0]        rd_cnt,
  output logic [(2**ID_SIZE)-1:0] inflight
);

  localparam int DEPTH = 2 ** ID_SIZE;

  DataType          data_q  [DEPTH];
  entry_state_e     state_q [DEPTH];
  logic [CNT_W-1:0] cnt_q   [DEPTH];

  // Payload capture; contents of FREE entries are don't-care, so no reset.
  always_ff @(posedge clk_i) begin
    if (wr_en) data_q[wr_id] <= wr_data;
  end

  // Entry lifecycle; a write only targets a FREE entry and a free only an INFLIGHT one.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) state_q[i] <= FREE;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (wr_en && wr_id == ID_SIZE'(i)) state_q[i] <= INFLIGHT;
        if (free_a_en && free_a_id == ID_SIZE'(i)) state_q[i] <= FREE;
        if (free_b_en && free_b_id == ID_SIZE'(i)) state_q[i] <= FREE;
      end
    end
  end

  // Retry counters: cleared on a fresh item, bumped each time it is re-issued.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (wr_en && wr_id == ID_SIZE'(i)) cnt_q[i] <= '0;
        else if (inc_en && inc_id == ID_SIZE'(i)) cnt_q[i] <= cnt_q[i] + CNT_W'(1);
      end
    end
  end

  // Flattened occupancy so the top can look up several IDs at once.
  always_comb begin
    inflight = '0;
    for (int i = 0; i < DEPTH; i++) inflight[i] = (state_q[i] == INFLIGHT);
  end

  assign rd_data = data_q[rd_id];
  assign rd_cnt  = cnt_q[cnt_id];

endmodule

// File: rtl/retry_budget_start.sv
// Retry source for the time-DMR retry loop. Tags accepted items with an
// ID, keeps a copy until done, re-issues on failure until the per-item
// retry budget is spent, then drops and reports the item.
// Optional statistics counters: define RETRY_BUDGET_START_STATS_EN.
module retry_budget_start
  import retry_pkg::*;
#(
  parameter type         DataType   = logic,
  parameter int unsigned ID_SIZE    = 4,
  parameter int unsigned MaxRetries = 3,
  parameter int unsigned CntWidth   = 16
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  DataType             data_i,
  input  logic                valid_i,
  output logic                ready_o,
  output DataType             data_o,
  output logic [ID_SIZE-1:0]  id_o,
  output logic                valid_o,
  input  logic                ready_i,
  input  logic [ID_SIZE-1:0]  failed_id_i,
  input  logic                failed_valid_i,
  output logic                failed_ready_o,
  input  logic [ID_SIZE-1:0]  done_id_i,
  input  logic                done_valid_i,
  output logic                exhausted_o,
  output logic [ID_SIZE-1:0]  exhausted_id_o,
  output logic [CntWidth-1:0] retry_cnt_o,
  output logic [CntWidth-1:0] drop_cnt_o
);

  localparam int unsigned       RC_W       = retry_cnt_width(MaxRetries);
  localparam logic [RC_W-1:0]   RC_MAX     = RC_W'(MaxRetries);
  localparam logic              ST_IDLE    = IDLE;
  localparam logic              ST_PENDING = PENDING;

  logic                    pending_q;
  logic [ID_SIZE-1:0]      pending_id_q;
  logic [ID_SIZE-1:0]      next_id_q;
  logic [(2**ID_SIZE)-1:0] inflight;
  DataType                 rd_data;
  logic [RC_W-1:0]         fail_cnt;

  logic slot_load;
  logic accept;
  logic done_hit;
  logic pend_live;
  logic issue_retry;
  logic fail_acc;
  logic fail_clash;
  logic fail_exhaust;
  logic fail_retry;

  assign slot_load      = !valid_o || ready_i;
  assign ready_o        = slot_load && (pending_q == ST_IDLE) && !inflight[next_id_q];
  assign failed_ready_o = (pending_q == ST_IDLE) || slot_load;
  assign accept         = valid_i && ready_o;
  assign done_hit       = done_valid_i && inflight[done_id_i];

  // A pending retry is only worth issuing if its entry is still alive this cycle.
  assign pend_live   = inflight[pending_id_q] && !(done_valid_i && done_id_i == pending_id_q);
  assign issue_retry = slot_load && (pending_q == ST_PENDING) && pend_live;

  assign fail_acc     = failed_valid_i && failed_ready_o;
  assign fail_clash   = fail_acc && done_valid_i && (done_id_i == failed_id_i);
  assign fail_exhaust = fail_acc && !fail_clash && inflight[failed_id_i] && (fail_cnt == RC_MAX);
  assign fail_retry   = fail_acc && !fail_clash && inflight[failed_id_i] && (fail_cnt != RC_MAX);

  retry_entry_table #(
    .DataType (DataType),
    .ID_SIZE  (ID_SIZE),
    .CNT_W    (RC_W)
  ) u_table (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .wr_en     (accept),
    .wr_id     (next_id_q),
    .wr_data   (data_i),
    .inc_en    (issue_retry),
    .inc_id    (pending_id_q),
    .free_a_en (done_hit),
    .free_a_id (done_id_i),
    .free_b_en (fail_exhaust),
    .free_b_id (failed_id_i),
    .rd_id     (pending_id_q),
    .rd_data   (rd_data),
    .cnt_id    (failed_id_i),
    .rd_cnt    (fail_cnt),
    .inflight  (inflight)
  );

  // Pending-retry register: a new failure can be latched while the old one leaves.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pending_q    <= ST_IDLE;
      pending_id_q <= '0;
    end else if (fail_retry) begin
      pending_q    <= ST_PENDING;
      pending_id_q <= failed_id_i;
    end else if (slot_load && pending_q == ST_PENDING) begin
      pending_q    <= ST_IDLE;
    end
  end

  // ID allocator walks IDs in order so the table fills and drains round-robin.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) next_id_q <= '0;
    else if (accept) next_id_q <= next_id_q + 1'b1;
  end

  // Output register: retries beat new data; content frozen while stalled.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_o <= 1'b0;
      data_o  <= '0;
      id_o    <= '0;
    end else if (slot_load) begin
      if (issue_retry) begin
        valid_o <= 1'b1;
        data_o  <= rd_data;
        id_o    <= pending_id_q;
      end else if (accept) begin
        valid_o <= 1'b1;
        data_o  <= data_i;
        id_o    <= next_id_q;
      end else begin
        valid_o <= 1'b0;
      end
    end
  end

  // Drop report: one-cycle pulse, ID held until the next drop.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      exhausted_o    <= 1'b0;
      exhausted_id_o <= '0;
    end else begin
      exhausted_o <= fail_exhaust;
      if (fail_exhaust) exhausted_id_o <= failed_id_i;
    end
  end

`ifdef RETRY_BUDGET_START_STATS_EN
  logic [CntWidth-1:0] retry_cnt_q;
  logic [CntWidth-1:0] drop_cnt_q;
  logic                drop_event;

  // Spurious reports (entry already FREE) are lumped in with budget drops.
  assign drop_event = (fail_acc && !fail_clash && !inflight[failed_id_i]) || fail_exhaust;

  // Saturating statistics counters.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      retry_cnt_q <= '0;
      drop_cnt_q  <= '0;
    end else begin
      if (issue_retry && retry_cnt_q != '1) retry_cnt_q <= retry_cnt_q + 1'b1;
      if (drop_event && drop_cnt_q != '1) drop_cnt_q <= drop_cnt_q + 1'b1;
    end
  end

  assign retry_cnt_o = retry_cnt_q;
  assign drop_cnt_o  = drop_cnt_q;
`else
  assign retry_cnt_o = '0;
  assign drop_cnt_o  = '0;
`endif

endmodule
